// File: rtl/depth_weights_seq.sv
// depth_weights_seq
//   Sequencer for the depthwise weight store. It owns the memory's
//   en/wr/rd/index pins and runs one of two operations at a time:
//     LOAD  - streams ld_count rows into consecutive addresses from 0,
//             accepting a row whenever ld_valid & ld_ready.
//     FETCH - reads fetch_blocks windows starting at fetch_base, one
//             window per read, stepping the index by GROUP. Each window
//             is offered to the PE array with w_valid/w_ready.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     load_start, ld_count          LOAD request (sampled in IDLE only)
//     ld_valid / ld_ready           row handshake while loading
//     fetch_start, fetch_base,
//     fetch_blocks                  FETCH request (sampled in IDLE only)
//     w_valid / w_ready             window handshake towards the PE array
//     mem_en, mem_wr, mem_rd,
//     mem_index                     weight store control
//     busy, done, err               status: not-idle, end pulse, reject pulse
//   Read timing: the read strobe is high for the single RD cycle, then the
//   sequencer waits RD_LAT cycles before raising w_valid, so the store's
//   data_out is settled well before the window is offered. A window
//   therefore takes at least 2+RD_LAT cycles.
module depth_weights_seq #(
  parameter int address_width = 12,
  parameter int height        = 2480,
  parameter int RD_LAT        = 1,
  parameter int GROUP         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [address_width-1:0] ld_count,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     fetch_start,
  input  logic [address_width-1:0] fetch_base,
  input  logic [7:0]               fetch_blocks,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic                     mem_rd,
  output logic [address_width-1:0] mem_index,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // Range checks run at a width wide enough that base + blocks*GROUP
  // can never wrap.
  localparam int                     EW       = address_width + 9;
  localparam logic [EW-1:0]          HEIGHT_E = EW'(height);
  localparam logic [EW-1:0]          GROUP_E  = EW'(GROUP);
  localparam logic [address_width-1:0] GROUP_A = address_width'(GROUP);
  localparam logic [address_width-1:0] ONE_A   = address_width'(1);
  localparam logic [7:0]             LAT_INIT = 8'(RD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_WAIT, S_HOLD, S_FIN} state_t;

  state_t                   state, state_nxt;
  logic [address_width-1:0] wcnt, ld_total, idx;
  logic [7:0]               bcnt, blk_total, lat;
  logic [EW-1:0]            fetch_end;
  logic                     ld_take, fe_take, ld_acc, hs, reject;

  assign fetch_end = EW'(fetch_base) + EW'(fetch_blocks) * GROUP_E;

  // Next-state decode and single-cycle strobes used by the counters.
  always_comb begin
    state_nxt = state;
    ld_take   = 1'b0;
    fe_take   = 1'b0;
    ld_acc    = 1'b0;
    hs        = 1'b0;
    reject    = 1'b0;
    case (state)
      S_IDLE: begin
        // load_start has priority when both requests arrive together.
        if (load_start) begin
          if (ld_count == '0) begin
            state_nxt = S_FIN;
          end else if (EW'(ld_count) > HEIGHT_E) begin
            reject = 1'b1;
          end else begin
            state_nxt = S_LOAD;
            ld_take   = 1'b1;
          end
        end else if (fetch_start) begin
          if (fetch_blocks == 8'd0) begin
            state_nxt = S_FIN;
          end else if (fetch_end > HEIGHT_E) begin
            reject = 1'b1;
          end else begin
            state_nxt = S_RD;
            fe_take   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready) begin
          ld_acc = 1'b1;
          if (wcnt + ONE_A == ld_total) state_nxt = S_FIN;
        end
      end
      S_RD:   state_nxt = S_WAIT;
      S_WAIT: if (lat == 8'd1) state_nxt = S_HOLD;
      S_HOLD: begin
        // w_ready only matters here; asserting it earlier has no effect.
        if (w_ready) begin
          hs = 1'b1;
          if (bcnt + 8'd1 == blk_total) state_nxt = S_FIN;
          else                          state_nxt = S_RD;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered status outputs, all derived from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ld_ready <= 1'b0;
      w_valid  <= 1'b0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ld_ready <= (state_nxt == S_LOAD);
      w_valid  <= (state_nxt == S_HOLD);
      mem_rd   <= (state_nxt == S_RD);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_FIN);
      err      <= reject;
    end
  end

  // Row, window and latency counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      ld_total  <= '0;
      idx       <= '0;
      bcnt      <= 8'd0;
      blk_total <= 8'd0;
      lat       <= 8'd0;
    end else begin
      if (ld_take) begin
        wcnt     <= '0;
        ld_total <= ld_count;
      end else if (ld_acc) begin
        wcnt <= wcnt + ONE_A;
      end

      if (fe_take) begin
        idx       <= fetch_base;
        bcnt      <= 8'd0;
        blk_total <= fetch_blocks;
      end else if (hs) begin
        idx  <= idx + GROUP_A;
        bcnt <= bcnt + 8'd1;
      end

      if (state == S_RD)        lat <= LAT_INIT;
      else if (state == S_WAIT) lat <= lat - 8'd1;
    end
  end

  // Write strobe follows the row handshake directly so a gap in ld_valid
  // writes nothing. The index stays on idx through WAIT/HOLD because the
  // store keeps data_out only while its address is unchanged.
  assign mem_wr = ld_valid & ld_ready;
  assign mem_en = mem_wr | mem_rd;

  always_comb begin
    mem_index = '0;
    case (state)
      S_LOAD:                mem_index = wcnt;
      S_RD, S_WAIT, S_HOLD:  mem_index = idx;
      default:               mem_index = '0;
    endcase
  end

endmodule

// File: tb/tb_depth_weights_seq.sv
module tb_depth_weights_seq;

  localparam int AW     = 12;
  localparam int HEIGHT = 2480;
  localparam int RD_LAT = 1;
  localparam int GROUP  = 16;

  logic          clk, rst;
  logic          load_start, ld_valid, ld_ready;
  logic [AW-1:0] ld_count, fetch_base, mem_index;
  logic          fetch_start, w_valid, w_ready;
  logic [7:0]    fetch_blocks;
  logic          mem_en, mem_wr, mem_rd, busy, done, err;

  depth_weights_seq #(.address_width(AW), .height(HEIGHT), .RD_LAT(RD_LAT), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .ld_count(ld_count), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .fetch_start(fetch_start), .fetch_base(fetch_base), .fetch_blocks(fetch_blocks),
    .w_valid(w_valid), .w_ready(w_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_index(mem_index),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight store model (single-cycle read latency) and expected contents.
  logic [31:0] data_in, data_out;
  logic [31:0] mem     [0:HEIGHT-1];
  logic [31:0] exp_mem [0:HEIGHT-1];

  always @(posedge clk) begin
    if (mem_en && mem_wr && mem_index < AW'(HEIGHT)) mem[mem_index] <= data_in;
    if (mem_en && mem_rd && mem_index < AW'(HEIGHT)) data_out <= mem[mem_index];
  end

  // Activity monitor, sampled mid-cycle.
  int  cyc = 0;
  int  rd_cyc = 0;
  int  lat_bad = 0, inv_bad = 0, done_cnt = 0;
  bit  mon_on = 1'b0;
  logic wv_prev = 1'b0;
  int  wr_log[$];
  int  rd_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_wr) wr_log.push_back(int'(mem_index));
      if (mem_rd) begin
        rd_log.push_back(int'(mem_index));
        rd_cyc <= cyc;
      end
      if (w_valid && !wv_prev && (cyc - rd_cyc != RD_LAT + 1)) lat_bad <= lat_bad + 1;
      wv_prev <= w_valid;
      if (done) done_cnt <= done_cnt + 1;
      if ((mem_wr && mem_rd) || (mem_en !== (mem_wr | mem_rd))) inv_bad <= inv_bad + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int n, input bit gaps, input logic [31:0] pat);
    int row = 0;
    int c = 0;
    int bad = 0;
    bit acc;
    wr_log.delete();
    ld_count = AW'(n);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    while (row < n && c < 400) begin
      ld_valid = !gaps || (c % 2 == 0);
      data_in  = pat + 32'(row);
      acc = ld_valid && ld_ready;
      if (acc) exp_mem[row] = pat + 32'(row);
      tick;
      c++;
      if (acc) row++;
    end
    ld_valid = 1'b0;
    check("load_rows", row, n);
    check("load_done_ready", {done, ld_ready}, 2'b10);
    tick;
    check("load_idle", {done, busy}, 2'b00);
    check("load_wr_count", wr_log.size(), n);
    foreach (wr_log[i]) if (wr_log[i] != i) bad++;
    check("load_wr_index", bad, 0);
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== exp_mem[i]) bad++;
    check("load_contents", bad, 0);
  endtask

  task automatic run_fetch(input int base, input int nblk, input int stall, input bit rdy_def);
    int k = 0;
    int c = 0;
    int bad = 0;
    int snap_n;
    int lat_snap;
    logic [AW-1:0] snap_i;
    rd_log.delete();
    lat_snap = lat_bad;
    w_ready = rdy_def;
    fetch_base = AW'(base);
    fetch_blocks = 8'(nblk);
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    while (k < nblk && c < 400) begin
      if (w_valid) begin
        if (stall > 0 && k == 0) begin
          snap_i = mem_index;
          snap_n = rd_log.size();
          repeat (stall) begin
            tick;
            if (!w_valid || mem_index !== snap_i || rd_log.size() != snap_n) bad++;
          end
          check("stall_stable", bad, 0);
        end
        w_ready = 1'b1;
        check("fetch_data", data_out, exp_mem[base + GROUP * k]);
        k++;
      end
      tick;
      c++;
      w_ready = rdy_def;
    end
    check("fetch_windows", k, nblk);
    check("fetch_done", {done, w_valid, mem_rd}, 3'b100);
    check("fetch_rd_count", rd_log.size(), nblk);
    bad = 0;
    foreach (rd_log[i]) if (rd_log[i] != base + GROUP * i) bad++;
    check("fetch_rd_index", bad, 0);
    check("fetch_latency", lat_bad - lat_snap, 0);
    tick;
    w_ready = 1'b0;
    check("fetch_idle", {done, busy}, 2'b00);
  endtask

  typedef struct {
    bit ld;
    int cnt;
    int base;
    int blk;
    bit e_err;
    bit e_busy;
    bit e_done;
    bit e_rd;
  } vec_t;

  vec_t vt[10];

  initial begin
    int done_snap;
    vt[0] = '{1'b1,    0,    0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 2481,    0,   0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 2480,    0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1,    1,    0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0,    0, 2470,   1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0,    0, 2464,   1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0,    0,    0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[7] = '{1'b0,    0,    0, 155, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b0,    0,    1, 155, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b0,    0, 4095, 255, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    load_start = 1'b0; ld_count = '0; ld_valid = 1'b0;
    fetch_start = 1'b0; fetch_base = '0; fetch_blocks = 8'd0;
    w_ready = 1'b0; data_in = '0;

    // Reset state
    tick;
    tick;
    check("reset_outputs",
          {ld_ready, w_valid, mem_en, mem_wr, mem_rd, mem_index, busy, done, err}, '0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick;

    // Request acceptance / range table
    foreach (vt[i]) begin
      if (vt[i].ld) begin
        ld_count = AW'(vt[i].cnt);
        load_start = 1'b1;
      end else begin
        fetch_base = AW'(vt[i].base);
        fetch_blocks = 8'(vt[i].blk);
        fetch_start = 1'b1;
      end
      tick;
      load_start = 1'b0;
      fetch_start = 1'b0;
      check($sformatf("vec%0d_err", i), err, vt[i].e_err);
      check($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d_done", i), done, vt[i].e_done);
      check($sformatf("vec%0d_rd", i), mem_rd, vt[i].e_rd);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check($sformatf("vec%0d_clear", i), {err, busy, done, mem_rd}, 4'b0000);
    end

    // Loads: continuous and gapped
    run_load(25, 1'b0, 32'h0000_1000);
    run_load(25, 1'b1, 32'h0000_2000);

    // Reset in the middle of a load
    wr_log.delete();
    done_snap = done_cnt;
    ld_count = AW'(25);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    ld_valid = 1'b1;
    data_in = 32'h0000_5555;
    repeat (3) tick;
    ld_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_outputs", {busy, ld_ready, done, mem_en, w_valid}, 5'b00000);
    repeat (3) tick;
    check("abort_no_done", done_cnt - done_snap, 0);
    check("abort_rows", wr_log.size(), 3);

    // Populate rows 0..47 for the fetch windows
    run_load(48, 1'b0, 32'h0000_3000);

    // Fetch with w_ready held high, then with backpressure
    run_fetch(0, 3, 0, 1'b1);
    run_fetch(16, 2, 10, 1'b0);

    // Simultaneous starts: load wins; fetch_start while busy is ignored
    rd_log.delete();
    wr_log.delete();
    ld_count = AW'(2);
    fetch_base = '0;
    fetch_blocks = 8'd1;
    load_start = 1'b1;
    fetch_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("contend_load_wins", {ld_ready, mem_rd}, 2'b10);
    ld_valid = 1'b1;
    data_in = 32'h0000_7000;
    exp_mem[0] = 32'h0000_7000;
    tick;
    data_in = 32'h0000_7001;
    exp_mem[1] = 32'h0000_7001;
    tick;
    ld_valid = 1'b0;
    fetch_start = 1'b0;
    check("contend_done", done, 1'b1);
    tick;
    tick;
    check("contend_idle", busy, 1'b0);
    check("contend_no_rd", rd_log.size(), 0);
    check("contend_writes", wr_log.size(), 2);
    check("contend_mem", {mem[0], mem[1]}, {exp_mem[0], exp_mem[1]});

    check("strobe_invariant", inv_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
